// File: rtl/mario_motion_pkg.sv
// Shared types and default tuning for the player motion path. The collision
// stage and the sprite selector import the same constants.
package mario_motion_pkg;

    localparam int VEL_W = 6;

    typedef logic [VEL_W-1:0] vel_t;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } air_state_t;

    // Which of Right_V / Left_V the horizontal magnitude belongs to.
    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } h_dir_t;

    localparam vel_t DEF_ACCEL        = 6'd1;
    localparam vel_t DEF_MAX_RUN      = 6'd4;
    localparam vel_t DEF_JUMP_V       = 6'd8;
    localparam int   DEF_JUMP_HOLD    = 12;
    localparam vel_t DEF_GRAVITY      = 6'd1;
    localparam vel_t DEF_TERMINAL_V   = 6'd8;
    localparam vel_t DEF_GROUND_PRESS = 6'd1;

    // a - b, clamped at zero.
    function automatic vel_t sat_sub(input vel_t a, input vel_t b);
        return (a > b) ? vel_t'(a - b) : '0;
    endfunction

    // a + b, clamped at lim. The sum is formed one bit wider so it cannot wrap.
    function automatic vel_t sat_add(input vel_t a, input vel_t b, input vel_t lim);
        logic [VEL_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[VEL_W-1:0];
    endfunction

endpackage

// File: rtl/mario_motion_ctrl_if.sv
// Frame-rate bundle between the input/contact decode (master) and the motion
// generator (slave): intent and contact flags in, four velocities out.
interface mario_motion_ctrl_if;
    import mario_motion_pkg::*;

    logic       frame_tick;
    logic       key_left;
    logic       key_right;
    logic       key_jump;
    logic       grounded;
    logic       hit_ceiling;
    vel_t       Right_V;
    vel_t       Left_V;
    vel_t       Up_V;
    vel_t       Down_V;
    air_state_t air_state;

    modport master (
        output frame_tick, key_left, key_right, key_jump, grounded, hit_ceiling,
        input  Right_V, Left_V, Up_V, Down_V, air_state
    );

    modport slave (
        input  frame_tick, key_left, key_right, key_jump, grounded, hit_ceiling,
        output Right_V, Left_V, Up_V, Down_V, air_state
    );

endinterface

// File: rtl/vel_ramp.sv
// One saturating velocity register. On a frame tick it loads a value, steps up
// by i_step (clamped to i_max) or steps down by i_step (clamped to 0).
module vel_ramp
    import mario_motion_pkg::*;
(
    input  logic Clk,
    input  logic Reset_n,
    input  logic i_tick,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_load,
    input  vel_t i_load_val,
    input  vel_t i_step,
    input  vel_t i_max,
    output vel_t o_val
);

    vel_t r_val;
    vel_t w_next;

    // Next value: a load beats ramping, increment beats decrement, else hold.
    always_comb begin
        // NOTE: default-assign first so every path drives w_next and no latch is inferred.
        w_next = r_val;
        if (i_load) begin
            w_next = i_load_val;
        end else if (i_inc) begin
            w_next = sat_add(r_val, i_step, i_max);
        end else if (i_dec) begin
            w_next = sat_sub(r_val, i_step);
        end
    end

    // Velocity register: synchronous reset, advances only on a frame tick.
    always_ff @(posedge Clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
        if (!Reset_n) begin
            r_val <= '0;
        end else if (i_tick) begin
            r_val <= w_next;
        end
    end

    assign o_val = r_val;

endmodule

// File: rtl/mario_motion_ctrl.sv
// Per-frame player motion generator: run accel/decel with reversal braking,
// variable-height jump, gravity and terminal fall speed. All outputs are
// registered and change only on frame_tick.
module mario_motion_ctrl
    import mario_motion_pkg::*;
#(
    parameter vel_t ACCEL        = DEF_ACCEL,
    parameter vel_t MAX_RUN      = DEF_MAX_RUN,
    parameter vel_t JUMP_V       = DEF_JUMP_V,
    parameter int   JUMP_HOLD    = DEF_JUMP_HOLD,
    parameter vel_t GRAVITY      = DEF_GRAVITY,
    parameter vel_t TERMINAL_V   = DEF_TERMINAL_V,
    parameter vel_t GROUND_PRESS = DEF_GROUND_PRESS
) (
    input logic                Clk,
    input logic                Reset_n,
    mario_motion_ctrl_if.slave bus
);

    localparam int HOLD_W = $clog2(JUMP_HOLD + 1);
    typedef logic [HOLD_W-1:0] hold_t;
    localparam hold_t HOLD_MAX = hold_t'(JUMP_HOLD);

    // ---------------- Horizontal ----------------
    logic   w_want_r;
    logic   w_want_l;
    logic   w_reverse;
    logic   w_h_inc;
    h_dir_t r_h_dir;
    vel_t   w_h_mag;

    assign w_want_r  = bus.key_right & ~bus.key_left;
    assign w_want_l  = bus.key_left & ~bus.key_right;
    // Pressing against existing motion brakes first; the turn happens at zero.
    assign w_reverse = (w_h_mag != '0) &&
                       ((w_want_r && r_h_dir == DIR_LEFT) || (w_want_l && r_h_dir == DIR_RIGHT));
    assign w_h_inc   = (w_want_r | w_want_l) & ~w_reverse;

    // Direction register: re-aimed only when speed is added, which implies zero speed the other way.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_h_dir <= DIR_RIGHT;
        end else if (bus.frame_tick && w_h_inc) begin
            r_h_dir <= w_want_l ? DIR_LEFT : DIR_RIGHT;
        end
    end

    vel_ramp u_h_ramp (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .i_tick     (bus.frame_tick),
        .i_inc      (w_h_inc),
        .i_dec      (~w_h_inc),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_step     (ACCEL),
        .i_max      (MAX_RUN),
        .o_val      (w_h_mag)
    );

    // ---------------- Vertical ----------------
    air_state_t r_state;
    air_state_t w_state_nxt;
    vel_t       r_up_v;
    vel_t       w_up_nxt;
    vel_t       w_up_dec;
    vel_t       w_dn_v;
    vel_t       w_dn_load_val;
    hold_t      r_hold_cnt;
    hold_t      w_hold_nxt;
    logic       r_jump_armed;
    logic       w_armed_nxt;
    logic       w_launch;
    logic       w_rise_hold;
    logic       w_dn_inc;
    logic       w_dn_load;

    assign w_launch    = (r_state == GROUND) && bus.grounded && bus.key_jump && r_jump_armed;
    assign w_rise_hold = bus.key_jump && (r_hold_cnt < HOLD_MAX);
    assign w_up_dec    = sat_sub(r_up_v, GRAVITY);
    // Releasing jump re-arms it; holding jump through a landing never relaunches.
    assign w_armed_nxt = w_launch ? 1'b0 : (r_jump_armed | ~bus.key_jump);

    // Vertical state and datapath registers, advanced on frame ticks.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state      <= FALL;
            r_up_v       <= '0;
            r_hold_cnt   <= '0;
            r_jump_armed <= 1'b0;
        end else if (bus.frame_tick) begin
            r_state      <= w_state_nxt;
            r_up_v       <= w_up_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_jump_armed <= w_armed_nxt;
        end
    end

    // Next-state decision: ceiling beats hold in RISE, landing beats jump in FALL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            GROUND: begin
                if (!bus.grounded)  w_state_nxt = FALL;
                else if (w_launch)  w_state_nxt = RISE;
            end
            RISE: begin
                if (bus.hit_ceiling)                      w_state_nxt = FALL;
                else if (!w_rise_hold && w_up_dec == '0)  w_state_nxt = FALL;
            end
            FALL: begin
                if (bus.grounded)   w_state_nxt = GROUND;
            end
            default: w_state_nxt = FALL;
        endcase
    end

    // Velocity and hold-counter updates that go with each state's transition.
    always_comb begin
        w_up_nxt      = r_up_v;
        w_hold_nxt    = r_hold_cnt;
        w_dn_inc      = 1'b0;
        w_dn_load     = 1'b0;
        w_dn_load_val = GROUND_PRESS;
        case (r_state)
            GROUND: begin
                w_up_nxt = '0;
                if (w_launch) begin
                    w_up_nxt      = JUMP_V;
                    w_hold_nxt    = hold_t'(1);
                    w_dn_load     = 1'b1;
                    w_dn_load_val = '0;
                end
            end
            RISE: begin
                if (bus.hit_ceiling) begin
                    w_up_nxt      = '0;
                    w_dn_load     = 1'b1;
                    w_dn_load_val = '0;
                end else if (w_rise_hold) begin
                    w_hold_nxt = r_hold_cnt + hold_t'(1);
                end else begin
                    // Pin the counter so re-pressing jump cannot extend a decaying rise.
                    w_hold_nxt = HOLD_MAX;
                    w_up_nxt   = w_up_dec;
                end
            end
            FALL: begin
                if (bus.grounded) begin
                    w_up_nxt  = '0;
                    w_dn_load = 1'b1;
                end else begin
                    w_dn_inc = 1'b1;
                end
            end
            default: begin
                w_up_nxt = '0;
            end
        endcase
    end

    vel_ramp u_dn_ramp (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .i_tick     (bus.frame_tick),
        .i_inc      (w_dn_inc),
        .i_dec      (1'b0),
        .i_load     (w_dn_load),
        .i_load_val (w_dn_load_val),
        .i_step     (GRAVITY),
        .i_max      (TERMINAL_V),
        .o_val      (w_dn_v)
    );

    assign bus.Right_V   = (r_h_dir == DIR_RIGHT) ? w_h_mag : '0;
    assign bus.Left_V    = (r_h_dir == DIR_LEFT)  ? w_h_mag : '0;
    assign bus.Up_V      = r_up_v;
    assign bus.Down_V    = w_dn_v;
    assign bus.air_state = r_state;

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Directed bench for mario_motion_ctrl: a table of per-tick vectors with
// hand-computed velocities, then hand sequences for tick gating, output
// latency and reset during a rise.
module tb_mario_motion_ctrl;
    import mario_motion_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n;

    mario_motion_ctrl_if bus ();

    mario_motion_ctrl dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        logic       rst_n;
        logic       key_left;
        logic       key_right;
        logic       key_jump;
        logic       grounded;
        logic       hit_ceiling;
        int         exp_r;
        int         exp_l;
        int         exp_u;
        int         exp_d;
        air_state_t exp_st;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input int rst_n, input int l, input int r, input int j, input int g,
                       input int c, input int er, input int el, input int eu, input int ed,
                       input air_state_t st);
        vec_t t;
        t.rst_n       = (rst_n != 0);
        t.key_left    = (l != 0);
        t.key_right   = (r != 0);
        t.key_jump    = (j != 0);
        t.grounded    = (g != 0);
        t.hit_ceiling = (c != 0);
        t.exp_r       = er;
        t.exp_l       = el;
        t.exp_u       = eu;
        t.exp_d       = ed;
        t.exp_st      = st;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int er, input int el, input int eu,
                         input int ed, input air_state_t st);
        n_vec++;
        if (bus.Right_V !== vel_t'(er) || bus.Left_V !== vel_t'(el) ||
            bus.Up_V !== vel_t'(eu) || bus.Down_V !== vel_t'(ed) || bus.air_state !== st) begin
            n_bad++;
            $display("FAIL %s: got R=%0d L=%0d U=%0d D=%0d st=%0d, expected R=%0d L=%0d U=%0d D=%0d st=%0d",
                     name, bus.Right_V, bus.Left_V, bus.Up_V, bus.Down_V, bus.air_state,
                     er, el, eu, ed, st);
        end
    endtask

    task automatic drive(input int l, input int r, input int j, input int g, input int c);
        bus.key_left    = (l != 0);
        bus.key_right   = (r != 0);
        bus.key_jump    = (j != 0);
        bus.grounded    = (g != 0);
        bus.hit_ceiling = (c != 0);
    endtask

    // One tick (or reset) edge, then two idle cycles so a check also proves outputs hold.
    task automatic apply(input vec_t t);
        @(negedge Clk);
        bus.key_left    = t.key_left;
        bus.key_right   = t.key_right;
        bus.key_jump    = t.key_jump;
        bus.grounded    = t.grounded;
        bus.hit_ceiling = t.hit_ceiling;
        Reset_n         = t.rst_n;
        bus.frame_tick  = 1'b1;
        @(negedge Clk);
        bus.frame_tick = 1'b0;
        Reset_n        = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    // Single tick; the caller samples 1 time unit after the tick edge.
    task automatic tick_once(input int l, input int r, input int j, input int g, input int c);
        @(negedge Clk);
        drive(l, r, j, g, c);
        bus.frame_tick = 1'b1;
        @(posedge Clk);
        #1;
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        Reset_n        = 1'b0;
        bus.frame_tick = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;

        // ---- table: rst, L, R, J, G, C | Right, Left, Up, Down, state ----
        add(0, 0,0,0,0,0, 0,0,0,0, FALL);                       // reset state
        for (int i = 1; i <= 10; i++)                           // free fall to terminal
            add(1, 0,0,0,0,0, 0,0,0, (i > 8) ? 8 : i, FALL);
        add(0, 0,0,0,0,0, 0,0,0,0, FALL);
        for (int i = 1; i <= 5; i++) add(1, 0,0,0,0,0, 0,0,0,i, FALL);
        add(1, 0,0,1,1,0, 0,0,0,1, GROUND);                     // land with jump: no launch
        add(1, 0,0,1,1,0, 0,0,8,0, RISE);                       // launch a tick later
        for (int i = 0; i < 11; i++) add(1, 0,0,1,0,0, 0,0,8,0, RISE);  // held: 12 ticks at 8
        for (int u = 7; u >= 1; u--) add(1, 0,0,1,0,0, 0,0,u,0, RISE);
        add(1, 0,0,1,0,0, 0,0,0,0, FALL);
        add(1, 0,0,1,0,0, 0,0,0,1, FALL);
        add(1, 0,0,1,0,0, 0,0,0,2, FALL);
        add(1, 0,0,1,1,0, 0,0,0,1, GROUND);                     // land with jump still held
        add(1, 0,0,1,1,0, 0,0,0,1, GROUND);
        add(1, 0,0,1,1,0, 0,0,0,1, GROUND);
        add(1, 0,0,0,1,0, 0,0,0,1, GROUND);                     // release re-arms
        add(1, 0,0,1,1,0, 0,0,8,0, RISE);                       // tap
        for (int u = 7; u >= 1; u--) add(1, 0,0,0,0,0, 0,0,u,0, RISE);
        add(1, 0,0,0,0,0, 0,0,0,0, FALL);
        add(1, 0,0,0,0,0, 0,0,0,1, FALL);
        add(1, 0,0,0,0,0, 0,0,0,2, FALL);
        add(1, 0,0,0,1,0, 0,0,0,1, GROUND);
        for (int i = 1; i <= 6; i++) add(1, 0,1,0,1,0, (i > 4) ? 4 : i, 0,0,1, GROUND);
        for (int i = 3; i >= 0; i--) add(1, 0,0,0,1,0, i, 0,0,1, GROUND);
        for (int i = 1; i <= 4; i++) add(1, 0,1,0,1,0, i, 0,0,1, GROUND);
        for (int i = 3; i >= 0; i--) add(1, 1,1,0,1,0, i, 0,0,1, GROUND);   // both keys
        for (int i = 1; i <= 4; i++) add(1, 0,1,0,1,0, i, 0,0,1, GROUND);
        for (int i = 3; i >= 0; i--) add(1, 1,0,0,1,0, i, 0,0,1, GROUND);   // reversal brake
        for (int i = 1; i <= 3; i++) add(1, 1,0,0,1,0, 0, i,0,1, GROUND);
        add(1, 0,1,0,1,0, 0,2,0,1, GROUND);
        add(1, 0,0,0,1,0, 0,1,0,1, GROUND);
        add(1, 0,0,0,1,0, 0,0,0,1, GROUND);
        add(1, 0,0,1,1,0, 0,0,8,0, RISE);                       // launch
        add(1, 0,0,1,0,0, 0,0,8,0, RISE);
        add(1, 0,0,1,0,0, 0,0,8,0, RISE);
        add(1, 0,0,1,0,1, 0,0,0,0, FALL);                       // ceiling on 3rd RISE tick
        add(1, 0,0,0,0,0, 0,0,0,1, FALL);
        add(1, 0,0,0,1,0, 0,0,0,1, GROUND);
        add(1, 0,0,1,0,0, 0,0,0,1, FALL);                       // walk off: carry press, no launch
        add(1, 0,0,0,0,0, 0,0,0,2, FALL);
        add(1, 0,1,0,0,0, 1,0,0,3, FALL);                       // air control
        add(1, 0,1,0,0,0, 2,0,0,4, FALL);
        add(1, 0,1,0,1,0, 3,0,0,1, GROUND);
        add(1, 0,1,1,1,0, 4,0,8,0, RISE);
        add(1, 0,1,1,0,0, 4,0,8,0, RISE);
        add(0, 0,1,1,0,0, 0,0,0,0, FALL);                       // reset mid-rise

        foreach (vecs[i]) begin
            apply(vecs[i]);
            check($sformatf("vec%0d", i), vecs[i].exp_r, vecs[i].exp_l,
                  vecs[i].exp_u, vecs[i].exp_d, vecs[i].exp_st);
        end

        // ---- outputs update the cycle after the tick ----
        tick_once(0, 1, 0, 0, 0);
        check("latency", 1, 0, 0, 1, FALL);

        // ---- no tick: outputs hold whatever the inputs do ----
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            drive(i % 2, (i + 1) % 2, 1, 1, 1);
            check($sformatf("hold%0d", i), 1, 0, 0, 1, FALL);
        end

        // ---- reset without a tick during a rise ----
        tick_once(0, 1, 0, 1, 0);
        check("land", 2, 0, 0, 1, GROUND);
        tick_once(0, 1, 1, 1, 0);
        check("launch", 3, 0, 8, 0, RISE);
        @(negedge Clk);
        Reset_n = 1'b0;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        check("rst_no_tick", 0, 0, 0, 0, FALL);
        tick_once(0, 0, 0, 0, 0);
        check("after_rst", 0, 0, 0, 1, FALL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mario_motion_ctrl.md
Name: mario_motion_ctrl

Overview:
- Per-frame player motion generator, directly upstream of the collision/position stage.
- Turns decoded keyboard intent plus ground/ceiling contact flags into the four unsigned directional velocities (Right_V, Left_V, Up_V, Down_V) that the collision stage consumes.
- Implements run acceleration/deceleration, variable-height jump, gravity and terminal fall speed.
- Runs on the 50 MHz system clock; state advances only on a one-cycle frame_tick.

Parameters:
- ACCEL, 1: horizontal speed change per frame (px/frame).
- MAX_RUN, 4: horizontal speed ceiling.
- JUMP_V, 8: launch Up_V.
- JUMP_HOLD, 12: max frames Up_V is held at JUMP_V while jump is held.
- GRAVITY, 1: vertical speed change per frame in rise/fall.
- TERMINAL_V, 8: Down_V ceiling.
- GROUND_PRESS, 1: Down_V while grounded (keeps floor contact detectable).

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-Clk pulse per frame (frame_clk rising edge synchronised into Clk).
- key_left  in  1  left held.
- key_right  in  1  right held.
- key_jump  in  1  jump held.
- grounded  in  1  floor contact this frame.
- hit_ceiling  in  1  upward motion blocked this frame.
- Right_V  out  6  rightward speed.
- Left_V  out  6  leftward speed.
- Up_V  out  6  upward speed.
- Down_V  out  6  downward speed.
- air_state  out  2  current vertical state (debug/sprite select).

Behaviour:
- Clocking and reset
  - Single clock Clk. Reset is synchronous, active-low (Reset_n).
  - Reset values: all velocities 0, state FALL, jump_armed 0, hold_cnt 0, air_state = FALL encoding.
  - Reset mid-operation (e.g. during a jump) applies the same values on the next Clk edge.
- Update timing
  - All registers change only on a Clk edge where frame_tick = 1. Outputs are valid the cycle after the tick.
  - No tick means outputs hold.
  - Outputs are registered; there is no combinational input-to-output path.
- Horizontal
  - dir = R if key_right & !key_left; L if key_left & !key_right; NONE otherwise (both keys or neither).
  - At most one of Right_V / Left_V is ever nonzero.
  - dir R:
    - If Left_V > 0, Left_V -= ACCEL, saturating at 0. This is reversal: decelerate before turning.
    - Otherwise Right_V = min(Right_V + ACCEL, MAX_RUN).
  - dir L: mirror image of dir R.
  - dir NONE: the nonzero one decrements by ACCEL, saturating at 0.
  - Horizontal motion is independent of vertical state (air control allowed).
- Vertical FSM: states GROUND, RISE, FALL.
  - jump_armed is set when key_jump = 0 on a tick and cleared on launch. Holding jump does not re-jump.
  - GROUND:
    - Outputs Up_V = 0, Down_V = GROUND_PRESS.
    - If !grounded → FALL, with Down_V = GROUND_PRESS carried over.
    - Else if key_jump & jump_armed → RISE, with Up_V = JUMP_V, Down_V = 0, hold_cnt = 1.
  - RISE:
    - hit_ceiling has priority: Up_V = 0, → FALL, Down_V = 0.
    - Else if key_jump & hold_cnt < JUMP_HOLD: Up_V holds, hold_cnt++.
    - Else Up_V -= GRAVITY. When the result is ≤ 0: Up_V = 0, → FALL.
    - Once decay starts, hold_cnt is forced to JUMP_HOLD; re-pressing jump does not re-extend.
  - FALL:
    - Down_V = min(Down_V + GRAVITY, TERMINAL_V).
    - If grounded → GROUND, with Down_V = GROUND_PRESS, Up_V = 0.
    - Landing wins over jump on the same tick. The jump can fire on a later tick if still armed.
  - Up_V and Down_V are never simultaneously nonzero.
- Arithmetic
  - All velocity math is 6-bit unsigned, saturating; no wrap-around.
  - Parameter legality: MAX_RUN, JUMP_V, TERMINAL_V ≤ 63; ACCEL, GRAVITY ≥ 1.

Decomposition:
- Package mario_motion_pkg:
  - Typedef air_state_t {GROUND, RISE, FALL}, 2-bit.
  - Velocity width constant VEL_W = 6.
  - Default tuning constants, shared with the collision stage and the sprite selector.
- Sub-module vel_ramp: one saturating accelerate/decelerate register with inputs inc, dec, step, max, tick.
  - Instantiated for the horizontal magnitude and for Down_V.

Test Plan:
- Reset, grounded = 0, 10 ticks → Down_V 1,2,…,8,8,8; Up_V, Right_V, Left_V = 0; no change between ticks.
- From FALL with Down_V = 5, grounded = 1 on a tick → GROUND, Down_V = 1, Up_V = 0; key_jump pulled high on the same tick → no launch on that tick.
- Grounded, key_right held 6 ticks → Right_V 1,2,3,4,4,4; release for 4 ticks → 3,2,1,0; both keys held → decays like release.
- Right_V = 4, key_left only → Right_V 3,2,1,0, then Left_V 1,2 (never both nonzero).
- Jump tap (1 tick) → Up_V 8,7,…,1, then FALL with Down_V 0,1,2; held jump → Up_V = 8 for 12 ticks, then decays; jump held through landing → no second launch until released.
- hit_ceiling at the 3rd RISE tick → Up_V = 0, FALL; Reset_n low mid-RISE → next Clk edge all velocities 0, state FALL.
